// File: rtl/loop_settle_monitor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : loop_settle_monitor_if                                        |
// | Purpose  : Stimulus/verdict bundle between a bench and the settle monitor|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface loop_settle_monitor_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
);
    logic             start;
    logic [WIDTH-1:0] obs;
    logic             busy;
    logic             done;
    logic             stable;
    logic             oscillating;
    logic [WIDTH-1:0] final_val;
    logic [CNT_W-1:0] settle_cnt;
    logic [CNT_W-1:0] toggle_cnt;
`ifdef LSM_PERIOD2_EN
    logic             period2;

    modport master (
        output start, obs,
        input  busy, done, stable, oscillating, final_val, settle_cnt, toggle_cnt, period2
    );
    modport slave (
        input  start, obs,
        output busy, done, stable, oscillating, final_val, settle_cnt, toggle_cnt, period2
    );
`else
    modport master (
        output start, obs,
        input  busy, done, stable, oscillating, final_val, settle_cnt, toggle_cnt
    );
    modport slave (
        input  start, obs,
        output busy, done, stable, oscillating, final_val, settle_cnt, toggle_cnt
    );
`endif
endinterface
`default_nettype wire

// File: rtl/loop_settle_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : loop_settle_monitor                                           |
// | Purpose  : Watches combinational-loop outputs after each start and       |
// |            declares them settled or oscillating. Optional macro          |
// |            LSM_PERIOD2_EN adds fast period-2 alternation detection.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module loop_settle_monitor #(
    parameter int WIDTH         = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int OSC_LIMIT     = 8,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    loop_settle_monitor_if.slave mon
);
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_arm    = 3'd1;
    localparam logic [2:0] c_st_watch  = 3'd2;
    localparam logic [2:0] c_st_stable = 3'd3;
    localparam logic [2:0] c_st_osc    = 3'd4;

    localparam logic [CNT_W-1:0] c_cnt_max    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_settle_lim = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] c_osc_lim    = CNT_W'(OSC_LIMIT);

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_prev;
    logic [CNT_W-1:0] r_run;
    logic [CNT_W-1:0] r_settle;
    logic [CNT_W-1:0] r_toggle;
    logic             r_busy;
    logic             r_done;
    logic             r_stable;
    logic             r_osc;
    logic [WIDTH-1:0] r_final;

    logic             w_eq;
    logic [CNT_W-1:0] w_settle_nxt;
    logic [CNT_W-1:0] w_run_nxt;
    logic [CNT_W-1:0] w_toggle_nxt;
    logic             w_hit_settle;
    logic             w_go_osc;

    // Exit decisions look at the post-update counter values of this edge
    assign w_eq         = (mon.obs == r_prev);
    assign w_settle_nxt = (r_settle == c_cnt_max) ? r_settle : r_settle + 1'b1;
    assign w_run_nxt    = !w_eq ? '0 : ((r_run == c_cnt_max) ? r_run : r_run + 1'b1);
    assign w_toggle_nxt = (w_eq || r_toggle == c_cnt_max) ? r_toggle : r_toggle + 1'b1;
    assign w_hit_settle = (w_run_nxt == c_settle_lim);

`ifdef LSM_PERIOD2_EN
    logic [WIDTH-1:0] r_prev2;
    logic [2:0]       r_alt;
    logic             r_period2;
    logic [2:0]       w_alt_nxt;
    logic             w_hit_p2;

    // A change that returns to the value two samples back extends the run;
    // any other change starts a new candidate run of length one.
    assign w_alt_nxt = w_eq ? 3'd0 : ((mon.obs == r_prev2) ? r_alt + 3'd1 : 3'd1);
    assign w_hit_p2  = (w_alt_nxt == 3'd4);
    assign w_go_osc  = (w_toggle_nxt == c_osc_lim) || (w_settle_nxt == c_cnt_max) || w_hit_p2;
    assign mon.period2 = r_period2;
`else
    assign w_go_osc  = (w_toggle_nxt == c_osc_lim) || (w_settle_nxt == c_cnt_max);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_prev   <= '0;
            r_run    <= '0;
            r_settle <= '0;
            r_toggle <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_stable <= 1'b0;
            r_osc    <= 1'b0;
            r_final  <= '0;
`ifdef LSM_PERIOD2_EN
            r_prev2   <= '0;
            r_alt     <= '0;
            r_period2 <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (mon.start) begin
                r_state  <= c_st_arm;
                r_prev   <= mon.obs;
                r_run    <= '0;
                r_settle <= '0;
                r_toggle <= '0;
                r_busy   <= 1'b1;
                r_stable <= 1'b0;
                r_osc    <= 1'b0;
                r_final  <= '0;
`ifdef LSM_PERIOD2_EN
                r_prev2   <= mon.obs;
                r_alt     <= '0;
                r_period2 <= 1'b0;
`endif
            end else begin
                case (r_state)
                    c_st_arm: r_state <= c_st_watch;
                    c_st_watch: begin
                        r_settle <= w_settle_nxt;
                        r_run    <= w_run_nxt;
                        r_toggle <= w_toggle_nxt;
                        r_prev   <= mon.obs;
`ifdef LSM_PERIOD2_EN
                        r_prev2  <= r_prev;
                        r_alt    <= w_alt_nxt;
`endif
                        if (w_hit_settle) begin
                            r_state  <= c_st_stable;
                            r_stable <= 1'b1;
                            r_final  <= mon.obs;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                        end else if (w_go_osc) begin
                            r_state <= c_st_osc;
                            r_osc   <= 1'b1;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
`ifdef LSM_PERIOD2_EN
                            r_period2 <= w_hit_p2;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mon.busy        = r_busy;
    assign mon.done        = r_done;
    assign mon.stable      = r_stable;
    assign mon.oscillating = r_osc;
    assign mon.final_val   = r_final;
    assign mon.settle_cnt  = r_settle;
    assign mon.toggle_cnt  = r_toggle;
endmodule
`default_nettype wire
